// File: rtl/program_loader_pkg.sv
// Shared constants for the program RAM loader: RAM geometry, FSM state
// encodings and the length-byte decoding helper.
package program_loader_pkg;

    localparam int PRAM_AW = 4;
    localparam int PRAM_DW = 8;

    // A length nibble of zero means "fill the whole program RAM".
    localparam bit LEN_ZERO_IS_MAX = 1'b1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_LEN     = 3'd1;
    localparam state_t ST_DATA    = 3'd2;
    localparam state_t ST_WRITE   = 3'd3;
    localparam state_t ST_SUM     = 3'd4;
    localparam state_t ST_RELEASE = 3'd5;
    localparam state_t ST_ERR     = 3'd6;

    // Number of words announced by a length nibble.
    function automatic logic [4:0] decode_len(
        input logic [3:0] nib,
        input int         max_words
    );
        if (nib != 4'd0)
            return {1'b0, nib};
        else if (LEN_ZERO_IS_MAX)
            return 5'(max_words);
        else
            return 5'd0;
    endfunction

endpackage

// File: rtl/loader_checksum.sv
// 8-bit XOR accumulator for the load stream.
// Ports: clk/rst; init loads din, accumulate XORs din in;
// match compares the running sum against cmp_data.
module loader_checksum
    import program_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               init,
    input  logic               accumulate,
    input  logic [PRAM_DW-1:0] din,
    input  logic [PRAM_DW-1:0] cmp_data,
    output logic               match
);

    logic [PRAM_DW-1:0] csum_q;
    logic [PRAM_DW-1:0] csum_d;

    always_comb begin
        csum_d = csum_q;
        if (init)
            csum_d = din;
        else if (accumulate)
            csum_d = csum_q ^ din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            csum_q <= '0;
        else
            csum_q <= csum_d;
    end

    assign match = (csum_q == cmp_data);

endmodule

// File: rtl/program_loader.sv
// Loads the four-bit computer's program RAM from a length/words/checksum
// byte stream, holding the PC in reset until a good checksum releases it.
// Ports: CLK/reset; start; in_data/in_valid/in_ready stream;
// PRAMAddress/PRAMData/PRAMWrite RAM port; StopPC/ResetPC PC control;
// busy/done/error status; words_loaded count.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int MAX_WORDS = 16
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               start,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [PRAM_AW-1:0] PRAMAddress,
    output logic [PRAM_DW-1:0] PRAMData,
    output logic               PRAMWrite,
    output logic               StopPC,
    output logic               ResetPC,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [4:0]         words_loaded
);

    state_t             state_q, state_d;
    logic [PRAM_AW-1:0] addr_q, addr_d;
    logic [PRAM_AW-1:0] waddr_q, waddr_d;
    logic [PRAM_DW-1:0] wdata_q, wdata_d;
    logic [4:0]         remaining_q, remaining_d;
    logic [4:0]         words_q, words_d;
    logic [4:0]         len_words;

    logic xfer;
    logic cs_init;
    logic cs_acc;
    logic cs_match;

    assign xfer      = in_valid && in_ready;
    assign len_words = decode_len(in_data[3:0], MAX_WORDS);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        remaining_d = remaining_q;
        words_d     = words_q;
        cs_init     = 1'b0;
        cs_acc      = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN;
                    words_d = '0;
                    addr_d  = '0;
                end
            end
            ST_LEN: begin
                if (xfer) begin
                    cs_init     = 1'b1;
                    remaining_d = len_words;
                    state_d     = (len_words == 5'd0) ? ST_SUM : ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    wdata_d = in_data;
                    waddr_d = addr_q;
                    cs_acc  = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                addr_d      = addr_q + 1'b1;
                words_d     = words_q + 5'd1;
                remaining_d = remaining_q - 5'd1;
                state_d     = (remaining_q == 5'd1) ? ST_SUM : ST_DATA;
            end
            ST_SUM: begin
                if (xfer)
                    state_d = cs_match ? ST_RELEASE : ST_ERR;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            remaining_q <= '0;
            words_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            remaining_q <= remaining_d;
            words_q     <= words_d;
        end
    end

    loader_checksum u_csum (
        .clk        (CLK),
        .rst        (reset),
        .init       (cs_init),
        .accumulate (cs_acc),
        .din        (in_data),
        .cmp_data   (in_data),
        .match      (cs_match)
    );

    // The computer ORs PRAMAddress into its PC address, so the RAM port
    // is gated to zero outside the single WRITE cycle.
    assign PRAMWrite   = (state_q == ST_WRITE);
    assign PRAMAddress = PRAMWrite ? waddr_q : '0;
    assign PRAMData    = PRAMWrite ? wdata_q : '0;

    assign in_ready = (state_q == ST_LEN) || (state_q == ST_DATA)
                   || (state_q == ST_SUM);
    assign busy     = in_ready || (state_q == ST_WRITE);
    assign StopPC   = busy || (state_q == ST_ERR);
    // RELEASE keeps the PC cleared for one cycle while letting it run.
    assign ResetPC  = StopPC || (state_q == ST_RELEASE);
    assign done     = (state_q == ST_RELEASE);
    assign error    = (state_q == ST_ERR);

    assign words_loaded = words_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected RAM writes and done/error
// events are queued by the driver and checked by a negedge monitor.
module tb_program_loader;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] PRAMAddress;
    logic [7:0] PRAMData;
    logic       PRAMWrite;
    logic       StopPC;
    logic       ResetPC;
    logic       busy;
    logic       done;
    logic       error;
    logic [4:0] words_loaded;

    program_loader #(.MAX_WORDS(16)) dut (
        .CLK          (CLK),
        .reset        (reset),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .PRAMAddress  (PRAMAddress),
        .PRAMData     (PRAMData),
        .PRAMWrite    (PRAMWrite),
        .StopPC       (StopPC),
        .ResetPC      (ResetPC),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    int         tests = 0;
    int         fails = 0;
    wr_t        exp_wr[$];
    logic [7:0] exp_ev[$];
    logic [7:0] vec[16];
    logic       tog = 1'b0;
    logic       prev_xfer;
    logic       err_prev = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge CLK or posedge reset) begin
        if (reset)
            prev_xfer <= 1'b0;
        else
            prev_xfer <= in_valid && in_ready;
    end

    always @(negedge CLK) begin
        wr_t        w;
        logic [7:0] ev;
        if (PRAMWrite) begin
            chk("wr_after_xfer", 32'(prev_xfer), 1);
            chk("no_ready_in_write", 32'(in_ready), 0);
            if (exp_wr.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: addr %0h data %0h",
                         PRAMAddress, PRAMData);
            end else begin
                w = exp_wr.pop_front();
                chk("wr_addr", 32'(PRAMAddress), 32'(w.a));
                chk("wr_data", 32'(PRAMData), 32'(w.d));
            end
        end else begin
            chk("pram_clean", 32'({PRAMAddress, PRAMData}), 0);
        end
        if (done) begin
            chk("done_resetpc", 32'(ResetPC), 1);
            chk("done_stoppc", 32'(StopPC), 0);
            ev = (exp_ev.size() != 0) ? exp_ev.pop_front() : 8'h00;
            chk("done_event", 32'(ev), 32'h44);
        end
        if (error && !err_prev) begin
            ev = (exp_ev.size() != 0) ? exp_ev.pop_front() : 8'h00;
            chk("error_event", 32'(ev), 32'h45);
        end
        err_prev <= error;
    end

    task automatic do_start();
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit stall);
        bit acc;
        bit ok;
        ok = 1'b0;
        in_data = b;
        for (int n = 0; n < 64; n++) begin
            in_valid = stall ? tog : 1'b1;
            tog = ~tog;
            acc = in_valid && in_ready;
            @(negedge CLK);
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("send_accepted", 32'(ok), 1);
    endtask

    task automatic load(input logic [7:0] len_b, input int n,
                        input logic [7:0] cs, input bit ok, input bit stall);
        for (int i = 0; i < n; i++)
            exp_wr.push_back('{a: 4'(i), d: vec[i]});
        exp_ev.push_back(ok ? 8'h44 : 8'h45);
        send(len_b, stall);
        for (int i = 0; i < n; i++)
            send(vec[i], stall);
        send(cs, stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge CLK);
        chk("rst_ctrl", 32'({in_ready, PRAMWrite, StopPC, ResetPC}), 0);
        chk("rst_status", 32'({busy, done, error}), 0);
        chk("rst_words", 32'(words_loaded), 0);
        reset = 1'b0;
        @(negedge CLK);

        // good load
        do_start();
        chk("start_pc", 32'({StopPC, ResetPC}), 32'h3);
        chk("start_ready", 32'(in_ready), 1);
        chk("start_busy", 32'(busy), 1);
        vec[0] = 8'h71; vec[1] = 8'h19; vec[2] = 8'h00;
        load(8'h03, 3, 8'h6B, 1'b1, 1'b0);
        chk("good_done", 32'(done), 1);
        @(negedge CLK);
        chk("good_idle_pc", 32'({StopPC, ResetPC}), 0);
        chk("good_idle_st", 32'({busy, done, error}), 0);
        chk("good_words", 32'(words_loaded), 3);

        // bad checksum
        do_start();
        load(8'h03, 3, 8'h6A, 1'b0, 1'b0);
        chk("bad_error", 32'(error), 1);
        repeat (3) @(negedge CLK);
        chk("bad_held", 32'({error, StopPC, ResetPC, done}), 32'hE);
        chk("bad_words", 32'(words_loaded), 3);
        do_start();
        chk("err_cleared", 32'(error), 0);
        chk("err_restart", 32'({busy, in_ready}), 32'h3);
        chk("err_words_clr", 32'(words_loaded), 0);

        // length 0 -> 16 words, checksum of {i,i} words is 0x00
        for (int i = 0; i < 16; i++)
            vec[i] = {4'(i), 4'(i)};
        load(8'h00, 16, 8'h00, 1'b1, 1'b0);
        chk("len0_done", 32'(done), 1);
        @(negedge CLK);
        chk("len0_words", 32'(words_loaded), 16);
        chk("len0_addr_wrap", 32'(dut.addr_q), 0);

        // stalled source
        do_start();
        vec[0] = 8'hA5; vec[1] = 8'h3C;
        load(8'h02, 2, 8'h9B, 1'b1, 1'b1);
        chk("stall_done", 32'(done), 1);
        @(negedge CLK);
        chk("stall_words", 32'(words_loaded), 2);

        // reset mid-load after the 2nd data byte
        do_start();
        exp_wr.push_back('{a: 4'h0, d: 8'h11});
        exp_wr.push_back('{a: 4'h1, d: 8'h22});
        send(8'h04, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_outs", 32'({in_ready, PRAMWrite, StopPC, ResetPC,
                                busy, done, error, PRAMAddress,
                                PRAMData, words_loaded}), 0);
        @(negedge CLK);
        reset = 1'b0;
        @(negedge CLK);
        do_start();
        vec[0] = 8'h5A; vec[1] = 8'hC3;
        load(8'h82, 2, 8'h1B, 1'b1, 1'b0);
        chk("reload_done", 32'(done), 1);
        @(negedge CLK);
        chk("reload_words", 32'(words_loaded), 2);

        // start pulsed while busy is ignored
        do_start();
        exp_wr.push_back('{a: 4'h0, d: 8'h0F});
        exp_wr.push_back('{a: 4'h1, d: 8'hF0});
        exp_ev.push_back(8'h44);
        send(8'h02, 1'b0);
        do_start();
        chk("busy_start_ign", 32'(busy), 1);
        send(8'h0F, 1'b0);
        do_start();
        send(8'hF0, 1'b0);
        send(8'hFD, 1'b0);
        chk("busy_start_done", 32'(done), 1);
        @(negedge CLK);
        chk("busy_start_words", 32'(words_loaded), 2);

        repeat (2) @(negedge CLK);
        chk("wr_queue_empty", 32'(exp_wr.size()), 0);
        chk("ev_queue_empty", 32'(exp_ev.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Front-end loader for the four-bit computer's program RAM. It accepts a byte stream over a valid/ready handshake: a length byte, then up to 16 instruction words, then an XOR checksum byte. Each instruction word is an opcode nibble plus a data nibble. While loading, the block drives the computer's PRAMAddress/PRAMData/PRAMWrite and holds its program counter in reset. After a good checksum it releases the computer to run from address 0.

## Interface
Parameters:
- MAX_WORDS, 16, program RAM depth; a length nibble of 0 means MAX_WORDS.

Ports:
- CLK  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-high; forces IDLE.
- start  in  1  begin load; sampled only in IDLE and ERR.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader can accept a byte this cycle.
- PRAMAddress  out  4  program RAM write address.
- PRAMData  out  8  program word; [7:4] opcode, [3:0] data.
- PRAMWrite  out  1  program RAM write strobe.
- StopPC  out  1  freeze PC and sub-counter.
- ResetPC  out  1  hold PC and sub-counter at 0.
- busy  out  1  high in LEN, DATA, WRITE and SUM.
- done  out  1  one-cycle pulse on a successful load.
- error  out  1  checksum mismatch; held high in ERR.
- words_loaded  out  5  words written in the current or last load (0..16).

Clock is CLK. reset is asynchronous and active-high.

## Operation
- A byte transfers on a posedge with in_valid && in_ready.
- in_ready = 1 in LEN, DATA and SUM; 0 in every other state.
- **IDLE**
  - StopPC = ResetPC = 0, so the computer runs.
  - On start: go to LEN, clear words_loaded, addr = 0.
- **LEN**
  - StopPC = ResetPC = 1.
  - On transfer: remaining = in_data[3:0] (0 → 16); csum = in_data; go to DATA.
  - in_data[7:4] is ignored but is included in csum.
- **DATA**
  - On transfer: register the byte into PRAMData and addr into PRAMAddress; csum ^= byte; go to WRITE.
- **WRITE** (exactly 1 cycle)
  - PRAMWrite = 1.
  - Then addr += 1 (4-bit wrap), words_loaded += 1, remaining -= 1.
  - Go to SUM if remaining reaches 0, else to DATA.
- **SUM**
  - On transfer: if in_data == csum, go to RELEASE; else go to ERR.
- **RELEASE** (1 cycle)
  - ResetPC = 1, StopPC = 0, done = 1; then go to IDLE.
  - The computer therefore starts from PC 0 with the sub-counter cleared.
- **ERR**
  - StopPC = ResetPC = 1, error = 1.
  - start clears error and goes to LEN.
- PRAMAddress and PRAMData are 0 in every state except WRITE. The computer ORs PRAMAddress with PCAddress, so these lines must be zero while it runs.
- start is ignored while busy.
- in_valid is ignored in states where in_ready = 0.

## Timing
- Reset values: state IDLE; in_ready, PRAMWrite, StopPC, ResetPC, busy, done, error = 0; PRAMAddress = 0; PRAMData = 0; words_loaded = 0; addr = 0; csum = 0.
- reset mid-load: immediate return to IDLE. Words already written stay in RAM, and the computer runs them.
- start at edge T: StopPC/ResetPC are high from T+; in_ready is high in cycle T+1.
- Data byte accepted at edge N: PRAMWrite is high for cycle N+1; the next byte can be accepted at edge N+2.
- Minimum load time for n words: 1 (start) + 1 (len) + 2n + 1 (sum) + 1 (release) cycles.
- The addr wrap 15 → 0 occurs only after the 16th write and is harmless.
- All outputs are registered or decoded from registered state; there are no combinational paths from in_valid.

## Structure
- Package program_loader_pkg holds:
  - the state enum (IDLE, LEN, DATA, WRITE, SUM, RELEASE, ERR);
  - PRAM_AW = 4;
  - PRAM_DW = 8;
  - the LEN_ZERO_IS_MAX constant.
- One sub-module, loader_checksum: an 8-bit XOR accumulator with init, accumulate and compare ports, driven by the FSM.
- program_loader itself holds the FSM, the addr/remaining/words_loaded counters and the output registers.

## Test plan
- **Good load:** start; bytes 0x03, 0x71, 0x19, 0x00, 0x6B → three PRAMWrite pulses at addresses 0, 1, 2 with data 0x71, 0x19, 0x00. Then done pulses once with ResetPC = 1 and StopPC = 0, then IDLE with both 0, and words_loaded = 3.
- **Bad checksum:** same stream with final byte 0x6A → ERR with error = 1 and StopPC = ResetPC = 1, held; no done pulse. A later start clears error.
- **Length 0:** length byte 0x00 followed by 16 words → writes at addresses 0..15, words_loaded = 16, address returns to 0 afterwards.
- **Stalled source:** in_valid toggled 1/0 every cycle during a 2-word load → no PRAMWrite without a prior transfer, and no byte accepted during WRITE.
- **Reset mid-load:** reset asserted after the 2nd data byte → all outputs are at reset values on the same cycle; the next start performs a full load.
- **Idle cleanliness:** start pulsed while busy → ignored. PRAMAddress and PRAMData are 0 in every non-WRITE cycle.
